// File: rtl/sram_axi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_axi_slave_if
//  Purpose  : AXI read/write channel bundle between the CDC bridge slave
//             port (master side) and the SRAM slave engine (slave side).
//  Revision : 1.0  initial release
// ============================================================================
interface sram_axi_slave_if;

    // Read address channel
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;

    // Read data channel
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RLAST_S;
    logic        RVALID_S;
    logic        RREADY_S;

    // Write address channel
    logic [7:0]  AWID_S;
    logic [31:0] AWADDR_S;
    logic [3:0]  AWLEN_S;
    logic [2:0]  AWSIZE_S;
    logic [1:0]  AWBURST_S;
    logic        AWVALID_S;
    logic        AWREADY_S;

    // Write data channel
    logic [31:0] WDATA_S;
    logic [3:0]  WSTRB_S;
    logic        WLAST_S;
    logic        WVALID_S;
    logic        WREADY_S;

    // Write response channel
    logic [7:0]  BID_S;
    logic [1:0]  BRESP_S;
    logic        BVALID_S;
    logic        BREADY_S;

    // Bridge side: issues requests, consumes responses
    modport master (
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        input  ARREADY_S,
        input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        output RREADY_S,
        output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        input  AWREADY_S,
        output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        input  WREADY_S,
        input  BID_S, BRESP_S, BVALID_S,
        output BREADY_S
    );

    // Engine side: accepts requests, produces responses
    modport slave (
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
        output ARREADY_S,
        output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
        input  RREADY_S,
        input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
        output AWREADY_S,
        input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
        output WREADY_S,
        output BID_S, BRESP_S, BVALID_S,
        input  BREADY_S
    );

endinterface
`default_nettype wire

// File: rtl/sram_axi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : sram_axi_slave
//  Purpose  : Single-transaction AXI slave engine serving a single-port
//             synchronous 32-bit SRAM one beat at a time. Writes win over
//             reads when both address channels are valid together.
//  Revision : 1.0  initial release
// ============================================================================
module sram_axi_slave #(
    parameter int ADDR_WIDTH = 14
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    sram_axi_slave_if.slave            axi,
    output logic                       sram_cs,
    output logic [3:0]                 sram_we,
    output logic [ADDR_WIDTH-1:0]      sram_addr,
    output logic [31:0]                sram_wdata,
    input  wire logic [31:0]           sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_DATA = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    localparam logic [1:0]            c_BURST_FIXED = 2'b00;
    localparam logic [1:0]            c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]            c_RESP_SLVERR = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Transaction context captured at the address handshake
    state_t                 r_state;
    logic [7:0]             r_id;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [3:0]             r_len;
    logic [3:0]             r_cnt;
    logic [1:0]             r_burst;
    logic                   r_err;

    logic                   w_last;
    logic [ADDR_WIDTH-1:0]  w_next_addr;
    logic [ADDR_WIDTH-1:0]  w_ar_word;
    logic [ADDR_WIDTH-1:0]  w_aw_word;
    logic                   w_wlast_bad;

    logic                   w_arready;
    logic                   w_awready;
    logic                   w_wready;
    logic                   w_rvalid;
    logic [31:0]            w_rdata;
    logic [7:0]             w_rid;
    logic                   w_rlast;
    logic                   w_bvalid;
    logic [7:0]             w_bid;
    logic [1:0]             w_bresp;
    logic                   w_cs;
    logic [3:0]             w_we;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [31:0]            w_wdata;

    // Byte-lane and out-of-range address bits plus SIZE carry no meaning here
    logic                   w_unused_bits;
    assign w_unused_bits = ^{axi.ARADDR_S[31:ADDR_WIDTH+2], axi.ARADDR_S[1:0],
                             axi.AWADDR_S[31:ADDR_WIDTH+2], axi.AWADDR_S[1:0],
                             axi.ARSIZE_S, axi.AWSIZE_S};

    assign w_ar_word   = axi.ARADDR_S[ADDR_WIDTH+1:2];
    assign w_aw_word   = axi.AWADDR_S[ADDR_WIDTH+1:2];
    assign w_last      = (r_cnt == r_len);
    // FIXED bursts replay one word; every other burst type walks upward and
    // wraps naturally at the top of the macro
    assign w_next_addr = (r_burst == c_BURST_FIXED) ? r_addr : (r_addr + c_ADDR_ONE);
    // WLAST only flags a protocol error; the beat count comes from LEN alone
    assign w_wlast_bad = (axi.WLAST_S != w_last);

    // Output decode from the current state and this cycle's inputs
    always_comb begin
        w_arready = 1'b0;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_rvalid  = 1'b0;
        w_rdata   = 32'd0;
        w_rid     = 8'd0;
        w_rlast   = 1'b0;
        w_bvalid  = 1'b0;
        w_bid     = 8'd0;
        w_bresp   = c_RESP_OKAY;
        w_cs      = 1'b0;
        w_we      = 4'b0000;
        w_addr    = {ADDR_WIDTH{1'b0}};
        w_wdata   = 32'd0;
        case (r_state)
            S_IDLE: begin
                w_awready = axi.AWVALID_S;
                w_arready = axi.ARVALID_S & ~axi.AWVALID_S;
            end
            S_RD_REQ: begin
                w_cs   = 1'b1;
                w_addr = r_addr;
            end
            S_RD_DATA: begin
                // SRAM output holds until the next access, so R stays stable
                w_rvalid = 1'b1;
                w_rdata  = sram_rdata;
                w_rid    = r_id;
                w_rlast  = w_last;
            end
            S_WR_DATA: begin
                w_wready = 1'b1;
                if (axi.WVALID_S) begin
                    w_cs    = 1'b1;
                    w_we    = axi.WSTRB_S;
                    w_addr  = r_addr;
                    w_wdata = axi.WDATA_S;
                end
            end
            S_WR_RESP: begin
                w_bvalid = 1'b1;
                w_bid    = r_id;
                w_bresp  = r_err ? c_RESP_SLVERR : c_RESP_OKAY;
            end
            default: begin
            end
        endcase
    end

    // Transaction sequencer: address capture, beat counting, response hand-off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_id    <= 8'd0;
            r_addr  <= {ADDR_WIDTH{1'b0}};
            r_len   <= 4'd0;
            r_cnt   <= 4'd0;
            r_burst <= 2'b00;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (axi.AWVALID_S) begin
                        r_id    <= axi.AWID_S;
                        r_addr  <= w_aw_word;
                        r_len   <= axi.AWLEN_S;
                        r_burst <= axi.AWBURST_S;
                        r_cnt   <= 4'd0;
                        r_err   <= 1'b0;
                        r_state <= S_WR_DATA;
                    end else if (axi.ARVALID_S) begin
                        r_id    <= axi.ARID_S;
                        r_addr  <= w_ar_word;
                        r_len   <= axi.ARLEN_S;
                        r_burst <= axi.ARBURST_S;
                        r_cnt   <= 4'd0;
                        r_err   <= 1'b0;
                        r_state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    r_state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (axi.RREADY_S) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 4'd1;
                            r_addr  <= w_next_addr;
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (axi.WVALID_S) begin
                        r_err <= r_err | w_wlast_bad;
                        if (w_last) begin
                            r_state <= S_WR_RESP;
                        end else begin
                            r_cnt  <= r_cnt + 4'd1;
                            r_addr <= w_next_addr;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (axi.BREADY_S) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign axi.ARREADY_S = w_arready;
    assign axi.AWREADY_S = w_awready;
    assign axi.WREADY_S  = w_wready;
    assign axi.RVALID_S  = w_rvalid;
    assign axi.RDATA_S   = w_rdata;
    assign axi.RID_S     = w_rid;
    assign axi.RRESP_S   = c_RESP_OKAY;
    assign axi.RLAST_S   = w_rlast;
    assign axi.BVALID_S  = w_bvalid;
    assign axi.BID_S     = w_bid;
    assign axi.BRESP_S   = w_bresp;

    assign sram_cs    = w_cs;
    assign sram_we    = w_we;
    assign sram_addr  = w_addr;
    assign sram_wdata = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_axi_slave
//  Purpose  : Scoreboard bench for sram_axi_slave with a behavioural SRAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_axi_slave;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          sram_cs;
    logic [3:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    always #5 clk = ~clk;

    sram_axi_slave_if axi ();

    sram_axi_slave #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .axi        (axi),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Behavioural single-port synchronous SRAM with a bench-side preload port
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (sram_cs) begin
            if (sram_we == 4'b0000) begin
                sram_rdata <= mem[sram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    typedef struct packed { logic [7:0] id; logic [31:0] data; logic last; } r_exp_t;
    typedef struct packed { logic [7:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [AW-1:0] addr; logic [3:0] we; logic [31:0] wdata; } s_exp_t;

    r_exp_t r_q[$];
    b_exp_t b_q[$];
    s_exp_t s_q[$];

    function automatic void exp_r(input logic [7:0] id, input logic [31:0] d, input logic l);
        r_exp_t e;
        e.id = id; e.data = d; e.last = l;
        r_q.push_back(e);
    endfunction

    function automatic void exp_b(input logic [7:0] id, input logic [1:0] resp);
        b_exp_t e;
        e.id = id; e.resp = resp;
        b_q.push_back(e);
    endfunction

    function automatic void exp_s(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d);
        s_exp_t e;
        e.addr = a; e.we = we; e.wdata = d;
        s_q.push_back(e);
    endfunction

    // Monitor: compares every presented R/B beat and SRAM access to the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (axi.RVALID_S) begin
                if (r_q.size() == 0) begin
                    fail_now("r_unexpected");
                end else begin
                    chk("rdata", axi.RDATA_S, r_q[0].data);
                    chk("rid",   32'(axi.RID_S), 32'(r_q[0].id));
                    chk("rlast", 32'(axi.RLAST_S), 32'(r_q[0].last));
                    chk("rresp", 32'(axi.RRESP_S), 32'd0);
                    if (axi.RREADY_S) void'(r_q.pop_front());
                end
            end
            if (axi.BVALID_S) begin
                if (b_q.size() == 0) begin
                    fail_now("b_unexpected");
                end else begin
                    chk("bid",   32'(axi.BID_S), 32'(b_q[0].id));
                    chk("bresp", 32'(axi.BRESP_S), 32'(b_q[0].resp));
                    if (axi.BREADY_S) void'(b_q.pop_front());
                end
            end
            if (sram_cs) begin
                if (s_q.size() == 0) begin
                    fail_now("sram_unexpected");
                end else begin
                    chk("sram_addr", 32'(sram_addr), 32'(s_q[0].addr));
                    chk("sram_we",   32'(sram_we), 32'(s_q[0].we));
                    if (s_q[0].we != 4'b0000) chk("sram_wdata", sram_wdata, s_q[0].wdata);
                    void'(s_q.pop_front());
                end
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input bit timing);
        bit ok = 1'b0;
        @(posedge clk); #1;
        axi.ARID_S = id; axi.ARADDR_S = addr; axi.ARLEN_S = len;
        axi.ARSIZE_S = 3'd2; axi.ARBURST_S = burst; axi.ARVALID_S = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (axi.ARREADY_S) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("ar_timeout");
        @(posedge clk); #1;
        axi.ARVALID_S = 1'b0;
        if (timing) begin
            @(negedge clk);
            chk("ar_cs_at_n1",     32'(sram_cs), 32'd1);
            chk("ar_rvalid_at_n1", 32'(axi.RVALID_S), 32'd0);
            @(negedge clk);
            chk("ar_rvalid_at_n2", 32'(axi.RVALID_S), 32'd1);
        end
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst);
        bit ok = 1'b0;
        @(posedge clk); #1;
        axi.AWID_S = id; axi.AWADDR_S = addr; axi.AWLEN_S = len;
        axi.AWSIZE_S = 3'd2; axi.AWBURST_S = burst; axi.AWVALID_S = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (axi.AWREADY_S) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("aw_timeout");
        @(posedge clk); #1;
        axi.AWVALID_S = 1'b0;
    endtask

    // Called just after a rising edge; leaves time just after the next handshake edge
    task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input logic last,
                          input bit final_chk);
        bit ok = 1'b0;
        axi.WDATA_S = d; axi.WSTRB_S = strb; axi.WLAST_S = last; axi.WVALID_S = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (axi.WREADY_S) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("w_timeout");
        @(posedge clk); #1;
        axi.WVALID_S = 1'b0; axi.WLAST_S = 1'b0;
        if (final_chk) begin
            @(negedge clk);
            chk("bvalid_after_last", 32'(axi.BVALID_S), 32'd1);
        end
    endtask

    task automatic drain(input bit toggle);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            axi.RREADY_S = toggle ? ~axi.RREADY_S : 1'b1;
            if (r_q.size() == 0 && b_q.size() == 0 && s_q.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("drain_timeout");
        axi.RREADY_S = 1'b1;
    endtask

    task automatic rd1(input logic [7:0] id, input logic [AW-1:0] word, input logic [31:0] d);
        exp_s(word, 4'b0000, 32'd0);
        exp_r(id, d, 1'b1);
        send_ar(id, 32'({word, 2'b00}), 4'd0, 2'b01, 1'b0);
        drain(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        axi.ARID_S = '0; axi.ARADDR_S = '0; axi.ARLEN_S = '0; axi.ARSIZE_S = '0;
        axi.ARBURST_S = '0; axi.ARVALID_S = 1'b0; axi.RREADY_S = 1'b0;
        axi.AWID_S = '0; axi.AWADDR_S = '0; axi.AWLEN_S = '0; axi.AWSIZE_S = '0;
        axi.AWBURST_S = '0; axi.AWVALID_S = 1'b0;
        axi.WDATA_S = '0; axi.WSTRB_S = '0; axi.WLAST_S = 1'b0; axi.WVALID_S = 1'b0;
        axi.BREADY_S = 1'b1;

        // Reset state and IDLE ready equations while held in reset
        #12;
        chk("rst_arready", 32'(axi.ARREADY_S), 32'd0);
        chk("rst_awready", 32'(axi.AWREADY_S), 32'd0);
        chk("rst_rvalid",  32'(axi.RVALID_S), 32'd0);
        chk("rst_bvalid",  32'(axi.BVALID_S), 32'd0);
        chk("rst_wready",  32'(axi.WREADY_S), 32'd0);
        chk("rst_cs",      32'(sram_cs), 32'd0);
        chk("rst_we",      32'(sram_we), 32'd0);
        axi.ARVALID_S = 1'b1; #1;
        chk("idle_arready_alone", 32'(axi.ARREADY_S), 32'd1);
        axi.AWVALID_S = 1'b1; #1;
        chk("idle_arready_both", 32'(axi.ARREADY_S), 32'd0);
        chk("idle_awready_both", 32'(axi.AWREADY_S), 32'd1);
        axi.ARVALID_S = 1'b0; axi.AWVALID_S = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read with latency check
        preload(14'h0010, 32'hDEADBEEF);
        axi.RREADY_S = 1'b1;
        exp_s(14'h0010, 4'b0000, 32'd0);
        exp_r(8'h03, 32'hDEADBEEF, 1'b1);
        send_ar(8'h03, 32'h0000_0040, 4'd0, 2'b01, 1'b1);
        drain(1'b0);

        // 4-beat INCR read wrapping past the top word, RREADY toggling
        preload(14'h3FFE, 32'hA0A0_0000);
        preload(14'h3FFF, 32'hA1A1_1111);
        preload(14'h0000, 32'hA2A2_2222);
        preload(14'h0001, 32'hA3A3_3333);
        exp_s(14'h3FFE, 4'b0000, 32'd0); exp_r(8'h22, 32'hA0A0_0000, 1'b0);
        exp_s(14'h3FFF, 4'b0000, 32'd0); exp_r(8'h22, 32'hA1A1_1111, 1'b0);
        exp_s(14'h0000, 4'b0000, 32'd0); exp_r(8'h22, 32'hA2A2_2222, 1'b0);
        exp_s(14'h0001, 4'b0000, 32'd0); exp_r(8'h22, 32'hA3A3_3333, 1'b1);
        axi.RREADY_S = 1'b0;
        send_ar(8'h22, 32'h1234_FFF8, 4'd3, 2'b01, 1'b0);
        drain(1'b1);

        // Two-beat write with partial strobe, then readback
        preload(14'h0041, 32'h5566_7788);
        exp_s(14'h0040, 4'b1111, 32'h1122_3344);
        exp_s(14'h0041, 4'b0011, 32'hAABB_CCDD);
        exp_b(8'h05, 2'b00);
        send_aw(8'h05, 32'h0000_0100, 4'd1, 2'b01);
        send_w(32'h1122_3344, 4'b1111, 1'b0, 1'b0);
        send_w(32'hAABB_CCDD, 4'b0011, 1'b1, 1'b1);
        drain(1'b0);
        rd1(8'h01, 14'h0040, 32'h1122_3344);
        rd1(8'h02, 14'h0041, 32'h5566_CCDD);

        // AR and AW together: write first, read then sees the written word
        exp_s(14'h0200, 4'b1111, 32'hCAFE_F00D);
        exp_b(8'h07, 2'b00);
        exp_s(14'h0200, 4'b0000, 32'd0);
        exp_r(8'h09, 32'hCAFE_F00D, 1'b1);
        @(posedge clk); #1;
        axi.AWID_S = 8'h07; axi.AWADDR_S = 32'h0000_0800; axi.AWLEN_S = 4'd0;
        axi.AWSIZE_S = 3'd2; axi.AWBURST_S = 2'b01; axi.AWVALID_S = 1'b1;
        axi.ARID_S = 8'h09; axi.ARADDR_S = 32'h0000_0800; axi.ARLEN_S = 4'd0;
        axi.ARSIZE_S = 3'd2; axi.ARBURST_S = 2'b01; axi.ARVALID_S = 1'b1;
        @(negedge clk);
        chk("both_awready", 32'(axi.AWREADY_S), 32'd1);
        chk("both_arready", 32'(axi.ARREADY_S), 32'd0);
        @(posedge clk); #1;
        axi.AWVALID_S = 1'b0;
        @(negedge clk);
        chk("ar_held_in_write", 32'(axi.ARREADY_S), 32'd0);
        @(posedge clk); #1;
        send_w(32'hCAFE_F00D, 4'b1111, 1'b1, 1'b1);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (axi.ARREADY_S) begin ok = 1'b1; break; end
            end
            if (!ok) fail_now("ar_after_b_timeout");
            @(posedge clk); #1;
            axi.ARVALID_S = 1'b0;
        end
        drain(1'b0);

        // Early WLAST on a 3-beat burst: all beats consumed, SLVERR
        exp_s(14'h0300, 4'b1111, 32'h0000_0A01);
        exp_s(14'h0301, 4'b1111, 32'h0000_0A02);
        exp_s(14'h0302, 4'b1111, 32'h0000_0A03);
        exp_b(8'h0A, 2'b10);
        send_aw(8'h0A, 32'h0000_0C00, 4'd2, 2'b01);
        send_w(32'h0000_0A01, 4'b1111, 1'b1, 1'b0);
        send_w(32'h0000_0A02, 4'b1111, 1'b0, 1'b0);
        send_w(32'h0000_0A03, 4'b1111, 1'b0, 1'b1);
        drain(1'b0);

        // FIXED burst: four writes land on the same word
        preload(14'h0051, 32'h5151_5151);
        for (int i = 1; i <= 4; i++) exp_s(14'h0050, 4'b1111, 32'(i));
        exp_b(8'h0C, 2'b00);
        send_aw(8'h0C, 32'h0000_0140, 4'd3, 2'b00);
        for (int i = 1; i <= 4; i++) send_w(32'(i), 4'b1111, (i == 4), (i == 4));
        drain(1'b0);
        rd1(8'h0D, 14'h0050, 32'h0000_0004);
        rd1(8'h0E, 14'h0051, 32'h5151_5151);

        // Reset during RD_DATA of beat 2: burst abandoned, next read is clean
        preload(14'h0020, 32'h2020_2020);
        preload(14'h0021, 32'h2121_2121);
        exp_s(14'h0020, 4'b0000, 32'd0); exp_r(8'h11, 32'h2020_2020, 1'b0);
        exp_s(14'h0021, 4'b0000, 32'd0); exp_r(8'h11, 32'h2121_2121, 1'b0);
        axi.RREADY_S = 1'b1;
        send_ar(8'h11, 32'h0000_0080, 4'd3, 2'b01, 1'b0);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(posedge clk); #1;
                if (r_q.size() == 1) begin ok = 1'b1; break; end
            end
            if (!ok) fail_now("beat1_timeout");
        end
        axi.RREADY_S = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_rvalid", 32'(axi.RVALID_S), 32'd1);
        #2; rst = 1'b1; #1;
        chk("mid_rst_rvalid", 32'(axi.RVALID_S), 32'd0);
        chk("mid_rst_rdata",  axi.RDATA_S, 32'd0);
        chk("mid_rst_rid",    32'(axi.RID_S), 32'd0);
        chk("mid_rst_rlast",  32'(axi.RLAST_S), 32'd0);
        chk("mid_rst_cs",     32'(sram_cs), 32'd0);
        chk("mid_rst_bvalid", 32'(axi.BVALID_S), 32'd0);
        chk("mid_rst_wready", 32'(axi.WREADY_S), 32'd0);
        chk("abandoned_r_left", 32'(r_q.size()), 32'd1);
        chk("abandoned_s_left", 32'(s_q.size()), 32'd0);
        r_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        axi.RREADY_S = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rd1(8'h12, 14'h0020, 32'h2020_2020);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
